shift_add_mul: RTL

Sequential 8x8 unsigned shift-and-add multiplier: one partial product per clock, 16-bit product, optional 8-bit addend. It is the inverse of the shift-subtract divider in the arithmetic datapath. Given quotient, divisor and remainder, it rebuilds the dividend (Q*D + R), which makes it the self-check for division results. It uses the same start/end handshake style as the divider and also serves as the plain multiply unit.

---
 rtl/shift_add_mul_if.sv | 21 ++
 rtl/shift_add_mul.sv | 108 ++++++++++
 2 files changed

// File: rtl/shift_add_mul_if.sv
// Start/end handshake and operand/result bus for the shift-and-add multiplier.
interface shift_add_mul_if;
  logic        ini_mul;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [7:0]  C;
  logic [15:0] product;
  logic        mulEnd;
  logic        busy;
  logic [2:0]  state;

  modport master (
    output ini_mul, A, B, C,
    input  product, mulEnd, busy, state
  );

  modport slave (
    input  ini_mul, A, B, C,
    output product, mulEnd, busy, state
  );
endinterface

// File: rtl/shift_add_mul.sv
// Sequential 8x8 unsigned multiplier, one partial product per clock; result A*B, or A*B+C
// when MUL_ADDEND_EN is defined (rebuilds Q*D+R to check divider results).
module shift_add_mul (
  input  logic             clk,
  input  logic             rst,
  shift_add_mul_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_ADDC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_m;
  logic [8:0]  r_hi;
  logic [7:0]  r_lo;
  logic [3:0]  r_cnt;
  logic [8:0]  w_t;
`ifdef MUL_ADDEND_EN
  logic [7:0]  r_cr;
  logic [15:0] w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = bus.ini_mul ? S_LOAD : S_IDLE;
      S_LOAD: w_next = S_STEP;
      S_STEP: begin
        if (r_cnt == 4'd1) begin
`ifdef MUL_ADDEND_EN
          w_next = S_ADDC;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_STEP;
        end
      end
`ifdef MUL_ADDEND_EN
      S_ADDC: w_next = S_DONE;
`endif
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // hi[8] is always zero entering a step, so the 9-bit sum cannot overflow
  assign w_t = r_lo[0] ? (r_hi + {1'b0, r_m}) : r_hi;
`ifdef MUL_ADDEND_EN
  assign w_sum = {r_hi[7:0], r_lo} + {8'h00, r_cr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
`ifdef MUL_ADDEND_EN
      r_cr  <= '0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          r_m   <= bus.A;
          r_lo  <= bus.B;
          r_hi  <= '0;
          r_cnt <= 4'd8;
`ifdef MUL_ADDEND_EN
          r_cr  <= bus.C;
`endif
        end
        S_STEP: begin
          {r_hi, r_lo} <= {1'b0, w_t, r_lo[7:1]};
          r_cnt        <= r_cnt - 4'd1;
        end
`ifdef MUL_ADDEND_EN
        S_ADDC: begin
          r_hi <= {1'b0, w_sum[15:8]};
          r_lo <= w_sum[7:0];
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.product = {r_hi[7:0], r_lo};
  assign bus.mulEnd  = (r_state == S_DONE);
  assign bus.busy    = (r_state == S_LOAD) || (r_state == S_STEP) ||
                       (r_state == S_ADDC) || (r_state == S_DONE);
  assign bus.state   = r_state;

endmodule
